// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the I2S DAC path.
// Holds the serializer state encoding and a saturating increment helper.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } i2s_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int UNDERFLOW_W = 16;

  function automatic logic [UNDERFLOW_W-1:0] sat_inc(
    input logic [UNDERFLOW_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stereo_sample_fifo.sv
// stereo_sample_fifo: synchronous FIFO of packed {left,right} frames.
// Ports: clk/rst_n, push+wdata, pop+rdata (show-ahead), full, empty, level.
module stereo_sample_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// i2s_dac_serializer: frame FIFO + I2S slave serializer driving DACDAT.
// Ports: clk_clk/reset_reset_n, in_left/in_right/in_valid/in_ready,
// audio_BCLK/audio_DACLRCK (codec-driven), audio_DACDAT, fifo_level,
// underflow_count (saturating count of left slots played as silence).
module i2s_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [DATA_W-1:0]           in_left,
  input  logic [DATA_W-1:0]           in_right,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        audio_BCLK,
  input  logic                        audio_DACLRCK,
  output logic                        audio_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [UNDERFLOW_W-1:0]      underflow_count
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic bclk_hist_q, bclk_hist_d;
  logic bclk_s, lrck_s, bclk_fall;

  i2s_state_t state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] right_hold_q, right_hold_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              lr_q, lr_d;
  logic              dacdat_q, dacdat_d;
  logic [UNDERFLOW_W-1:0] underflow_q, underflow_d;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic lr_chg, slot_right, left_pop, left_dry;

  stereo_sample_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (fifo_push),
    .wdata ({in_left, in_right}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready        = ~fifo_full;
  assign fifo_push       = in_valid & in_ready;
  assign audio_DACDAT    = dacdat_q;
  assign underflow_count = underflow_q;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign bclk_fall = bclk_hist_q & ~bclk_s;

  // LRCK and BCLK share the same sync depth, so at the detected fall
  // lrck_s already shows the value the codec launched on that edge.
  assign lr_chg     = bclk_fall & (lrck_s != lr_q);
  assign slot_right = lrck_s;
  assign left_pop   = ~lrck_s & ~fifo_empty;
  assign left_dry   = ~lrck_s & fifo_empty;

  always_comb begin
    bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], audio_BCLK};
    lrck_sync_d  = {lrck_sync_q[SYNC_STAGES-2:0], audio_DACLRCK};
    bclk_hist_d  = bclk_s;
    state_d      = state_q;
    shreg_d      = shreg_q;
    right_hold_d = right_hold_q;
    bit_cnt_d    = bit_cnt_q;
    lr_d         = lr_q;
    dacdat_d     = dacdat_q;
    underflow_d  = underflow_q;
    fifo_pop     = 1'b0;

    if (bclk_fall) begin
      lr_d     = lrck_s;
      // On a slot-change fall still in SHIFT this emits the in-flight
      // bit, which is the I2S LSB slot of the word just ending.
      dacdat_d = (state_q == SHIFT) & shreg_q[DATA_W-1];

      unique case (state_q)
        IDLE: begin
          if (lr_q & ~lrck_s) state_d = ARMED;
        end
        SHIFT: begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = PAD;
        end
        default: ;
      endcase

      // Slot boundary: also aborts a short frame mid-word.
      if ((state_q != IDLE) && lr_chg) begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
        unique case (1'b1)
          slot_right: begin
            shreg_d = right_hold_q;
          end
          left_pop: begin
            fifo_pop     = 1'b1;
            shreg_d      = fifo_rdata[2*DATA_W-1:DATA_W];
            right_hold_d = fifo_rdata[DATA_W-1:0];
          end
          left_dry: begin
            shreg_d      = '0;
            right_hold_d = '0;
            underflow_d  = sat_inc(underflow_q);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      bclk_hist_q  <= 1'b0;
      state_q      <= IDLE;
      shreg_q      <= '0;
      right_hold_q <= '0;
      bit_cnt_q    <= '0;
      lr_q         <= 1'b0;
      dacdat_q     <= 1'b0;
      underflow_q  <= '0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrck_sync_q  <= lrck_sync_d;
      bclk_hist_q  <= bclk_hist_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      right_hold_q <= right_hold_d;
      bit_cnt_q    <= bit_cnt_d;
      lr_q         <= lr_d;
      dacdat_q     <= dacdat_d;
      underflow_q  <= underflow_d;
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb_i2s_dac_serializer: random-stimulus bench with a slot-level model.
// Drives codec clocks, pushes frames and checks DACDAT every cycle.
module tb_i2s_dac_serializer;

  localparam int DW = 24;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic [DW-1:0] in_left, in_right;
  logic in_valid, in_ready;
  logic audio_BCLK, audio_DACLRCK, audio_DACDAT;
  logic [2:0] fifo_level;
  logic [15:0] underflow_count;

  i2s_dac_serializer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .in_left         (in_left),
    .in_right        (in_right),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .audio_BCLK      (audio_BCLK),
    .audio_DACLRCK   (audio_DACLRCK),
    .audio_DACDAT    (audio_DACDAT),
    .fifo_level      (fifo_level),
    .underflow_count (underflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  // Model state: slot-level view of the I2S stream.
  logic        m_lr, m_armed, m_play;
  int          m_k;
  logic [DW-1:0] m_word, m_hold;
  logic [15:0] m_uf;
  logic [2*DW-1:0] mq[$];
  logic exp_now, exp_d1, exp_d2, exp_d3;
  logic [63:0] cap = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lr = 1'b0; m_armed = 1'b0; m_play = 1'b0; m_k = 0;
    m_word = '0; m_hold = '0; m_uf = '0; exp_now = 1'b0;
    mq.delete();
  endtask

  // One BCLK fall carrying LRCK value new_lr: emit bit k of the slot,
  // then open a new slot if LRCK changed.
  task automatic model_fall(input logic new_lr);
    logic [2*DW-1:0] f;
    m_k++;
    exp_now = (m_play && m_k <= DW) ? m_word[DW - m_k] : 1'b0;
    if (new_lr != m_lr) begin
      if (!m_armed) begin
        if (m_lr && !new_lr) m_armed = 1'b1;
      end else begin
        m_play = 1'b1;
        m_k = 0;
        if (!new_lr) begin
          if (mq.size() > 0) begin
            f = mq.pop_front();
            m_word = f[2*DW-1:DW];
            m_hold = f[DW-1:0];
          end else begin
            m_word = '0;
            m_hold = '0;
            if (m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
          end
        end else begin
          m_word = m_hold;
        end
      end
    end
    m_lr = new_lr;
  endtask

  // DACDAT must follow a pin fall by exactly three clk_clk edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_d1 <= 1'b0; exp_d2 <= 1'b0; exp_d3 <= 1'b0;
    end else begin
      exp_d1 <= exp_now; exp_d2 <= exp_d1; exp_d3 <= exp_d2;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en)
      chk("dacdat_stream", 64'(audio_DACDAT), 64'(exp_d3));
  end

  task automatic do_fall(input logic lr);
    @(negedge clk);
    audio_BCLK = 1'b0;
    audio_DACLRCK = lr;
    model_fall(lr);
    repeat (3) @(posedge clk);
    #1 cap = {cap[62:0], audio_DACDAT};
    @(negedge clk);
  endtask

  task automatic do_rise();
    @(negedge clk);
    audio_BCLK = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic play_slot(input logic lr, input int n);
    for (int i = 0; i < n; i++) begin
      do_fall(lr);
      do_rise();
    end
  endtask

  task automatic play_frame(input int nl, input int nr);
    play_slot(1'b0, nl);
    play_slot(1'b1, nr);
  endtask

  task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic acc;
    @(negedge clk);
    in_left = l;
    in_right = r;
    in_valid = 1'b1;
    acc = (mq.size() < DEPTH);
    chk("in_ready_push", 64'(in_ready), 64'(acc));
    if (acc) mq.push_back({l, r});
  endtask

  task automatic end_push();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"}, 64'(fifo_level), 64'(mq.size()));
    chk({tag, "_uf"}, 64'(underflow_count), 64'(m_uf));
    chk({tag, "_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_left = '0; in_right = '0; in_valid = 1'b0;
    audio_BCLK = 1'b1; audio_DACLRCK = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dacdat", 64'(audio_DACDAT), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_uf", 64'(underflow_count), 64'(0));
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("post_rst_dacdat", 64'(audio_DACDAT), 64'(0));

    // Basic frame: lead-in right slot, arming frame, then audible frame.
    push_frame(24'hA5F00F, 24'h123456);
    end_push();
    chk("push_level", 64'(fifo_level), 64'(1));
    play_slot(1'b1, 32);
    play_frame(32, 32);
    chk("arm_level", 64'(fifo_level), 64'(1));
    play_frame(32, 32);
    chk("basic_left", 64'(cap[62:31]), 64'({24'hA5F00F, 8'h00}));
    chk("basic_right", 64'(cap[30:0]), 64'({24'h123456, 7'h00}));
    chk("basic_uf", 64'(underflow_count), 64'(0));
    check_state("basic");

    // Empty FIFO: three silent frames.
    for (int i = 0; i < 3; i++) play_frame(32, 32);
    chk("empty_uf", 64'(underflow_count), 64'(3));
    chk("empty_level", 64'(fifo_level), 64'(0));
    check_state("empty");

    // Full FIFO: five back-to-back offers, the fifth refused.
    for (int i = 0; i < 5; i++)
      push_frame(DW'($urandom), DW'($urandom));
    end_push();
    chk("full_level", 64'(fifo_level), 64'(4));
    chk("full_ready", 64'(in_ready), 64'(0));
    play_slot(1'b0, 32);
    chk("pop_level", 64'(fifo_level), 64'(3));
    chk("pop_ready", 64'(in_ready), 64'(1));
    play_slot(1'b1, 32);

    // Short frames in each channel.
    play_frame(10, 32);
    play_frame(32, 10);
    chk("short_level", 64'(fifo_level), 64'(1));
    check_state("short");

    // Random traffic with random slot lengths.
    for (int it = 0; it < 6; it++) begin
      int np;
      np = int'($urandom_range(0, 2));
      for (int j = 0; j < np; j++)
        push_frame(DW'($urandom), DW'($urandom));
      end_push();
      play_frame(int'($urandom_range(8, 40)), int'($urandom_range(8, 40)));
      check_state("rand");
    end
    while (mq.size() > 0) play_frame(32, 32);

    // Reset mid-word while an all-ones left word is on the wire.
    push_frame(24'hFFFFFF, DW'($urandom));
    end_push();
    do_fall(1'b0);
    do_rise();
    play_slot(1'b0, 4);
    do_fall(1'b0);
    chk("pre_reset_bit", 64'(audio_DACDAT), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk("reset_async_dacdat", 64'(audio_DACDAT), 64'(0));
    model_reset();
    @(negedge clk);
    chk("midrst_level", 64'(fifo_level), 64'(0));
    chk("midrst_ready", 64'(in_ready), 64'(1));
    chk("midrst_uf", 64'(underflow_count), 64'(0));
    rst_n = 1'b1;
    do_rise();
    play_slot(1'b0, 10);
    push_frame(DW'($urandom), DW'($urandom));
    end_push();
    play_slot(1'b1, 32);
    play_frame(32, 32);
    chk("rearm_level", 64'(fifo_level), 64'(1));
    play_frame(32, 32);
    chk("replay_level", 64'(fifo_level), 64'(0));
    check_state("restart");

    // Counter saturation from a preset near the top.
    @(negedge clk);
    force dut.underflow_q = 16'hFFFE;
    @(negedge clk);
    release dut.underflow_q;
    m_uf = 16'hFFFE;
    @(negedge clk);
    chk("preset_uf", 64'(underflow_count), 64'(16'hFFFE));
    for (int i = 0; i < 3; i++) play_frame(32, 32);
    chk("sat_uf", 64'(underflow_count), 64'(16'hFFFF));
    check_state("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
